// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES pad poller: button bit positions and FSM states.
// Pure declarations; no timing or flow control.
package nes_pad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT0,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

endpackage

// File: rtl/nes_pad_poller_if.sv
// Pad GPIO lines plus the core-facing poll request and button results.
// slave = poller view, master = game logic / pad side view.
interface nes_pad_poller_if;
  logic       iStart;
  logic       iAuto_EN;
  logic       iNES_DATA;
  logic       oNES_LATCH;
  logic       oNES_CLK;
  logic [7:0] oButtons;
  logic [7:0] oPressed;
  logic       oValid;
  logic       oBusy;

  modport slave (
    input  iStart, iAuto_EN, iNES_DATA,
    output oNES_LATCH, oNES_CLK, oButtons, oPressed, oValid, oBusy
  );

  modport master (
    output iStart, iAuto_EN, iNES_DATA,
    input  oNES_LATCH, oNES_CLK, oButtons, oPressed, oValid, oBusy
  );
endinterface

// File: rtl/nes_pad_sync.sv
// 2-flop synchronizer for the active-low pad data line; output is 1 = pressed.
// Latency 2 cycles; no backpressure. Resets to the pulled-up (released) level.
module nes_pad_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic bit_dat
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= raw_n;
      sync_q <= meta_q;
    end
  end

  assign bit_dat = ~sync_q;
endmodule

// File: rtl/nes_pad_poller.sv
// Drives NES latch/clock, shifts in 8 buttons, publishes registered state + press edges.
// LATCH+15*HALF+1 cycles per poll; triggers while busy collapse into one pending poll.
module nes_pad_poller
  import nes_pad_pkg::*;
#(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input logic             iCLK,
  input logic             iRST,
  nes_pad_poller_if.slave pad
);
  localparam int CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(POLL_CYCLES + 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [PW-1:0] poll_cnt;
  logic          pending;
  logic          trig;
  logic          data;

  nes_pad_sync u_sync (
    .clk     (iCLK),
    .rst     (iRST),
    .raw_n   (pad.iNES_DATA),
    .bit_dat (data)
  );

  assign trig = pad.iStart | (pad.iAuto_EN & (poll_cnt == POLL_LAST));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      poll_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      if (!pad.iAuto_EN || poll_cnt == POLL_LAST) poll_cnt <= '0;
      else                                         poll_cnt <= poll_cnt + 1'b1;
      // IDLE is the consume point, so a pending request never survives it.
      if (state == IDLE)  pending <= 1'b0;
      else if (trig)      pending <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (trig || pending) state_nxt = LATCH;
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_nxt = WAIT0;
          cnt_nxt   = '0;
        end
      end
      WAIT0: begin
        if (cnt == HALF_LAST) begin
          shift_nxt[BTN_A] = data;
          bit_nxt          = 3'd1;
          state_nxt        = CLK_HI;
          cnt_nxt          = '0;
        end
      end
      CLK_HI: begin
        if (cnt == HALF_LAST) begin
          state_nxt = CLK_LO;
          cnt_nxt   = '0;
        end
      end
      CLK_LO: begin
        if (cnt == HALF_LAST) begin
          shift_nxt[bit_cnt] = data;
          cnt_nxt            = '0;
          if (bit_cnt == 3'(BTN_RIGHT)) begin
            state_nxt = DONE;
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            state_nxt = CLK_HI;
          end
        end
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      pad.oNES_LATCH <= 1'b0;
      pad.oNES_CLK   <= 1'b0;
      pad.oButtons   <= '0;
      pad.oPressed   <= '0;
      pad.oValid     <= 1'b0;
      pad.oBusy      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bit_cnt        <= bit_nxt;
      shift          <= shift_nxt;
      pad.oNES_LATCH <= (state_nxt == LATCH);
      pad.oNES_CLK   <= (state_nxt == CLK_HI);
      pad.oBusy      <= (state_nxt != IDLE);
      pad.oValid     <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        pad.oButtons <= shift_nxt;
        pad.oPressed <= shift_nxt & ~pad.oButtons;
      end else begin
        pad.oPressed <= '0;
      end
    end
  end
endmodule
